// File: rtl/mux_unstriping_n.sv
// Round-robin unstriping mux: LANES input lanes, each with a DEPTH-entry FIFO,
// merged into one registered valid/ready word stream.
module mux_unstriping_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_2f,
    input  logic                       reset_L,
    input  logic [LANES*WIDTH-1:0]     data_in,
    input  logic [LANES-1:0]           valid_in,
    input  logic [$clog2(LANES):0]     active_lanes,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [$clog2(LANES)-1:0]   lane_ptr,
    output logic [LANES-1:0]           full,
    output logic [LANES-1:0]           overflow
);

    localparam int unsigned PW = $clog2(LANES);
    localparam int unsigned NW = PW + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q    [LANES][DEPTH];
    logic [AW-1:0]    wr_ptr_q [LANES];
    logic [AW-1:0]    rd_ptr_q [LANES];
    logic [CW-1:0]    cnt_q    [LANES];
    logic [LANES-1:0] overflow_q;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic [PW-1:0]    lane_ptr_q, lane_ptr_d;
    logic [NW-1:0]    n_eff_q, n_eff_d;

    logic [NW-1:0]    n_req;
    logic             load;
    logic             all_empty;
    logic             reload;
    logic             any_pop;
    logic             ptr_wrap;
    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;
    logic [WIDTH-1:0] head;

    always_comb begin
        n_req     = ((active_lanes == '0) || (active_lanes > NW'(LANES))) ? NW'(LANES) : active_lanes;
        load      = !valid_out_q || out_ready;
        all_empty = 1'b1;
        for (int unsigned k = 0; k < LANES; k++) begin
            // full is taken before any pop, so a push into a full FIFO is dropped
            full[k]   = (cnt_q[k] == CW'(DEPTH));
            push[k]   = valid_in[k] && !full[k];
            pop[k]    = load && (lane_ptr_q == PW'(k)) && (cnt_q[k] != '0);
            all_empty = all_empty && (cnt_q[k] == '0);
        end
        any_pop  = |pop;
        head     = mem_q[lane_ptr_q][rd_ptr_q[lane_ptr_q]];
        ptr_wrap = ((NW'(lane_ptr_q) + NW'(1)) == n_eff_q);
        reload   = all_empty && load && (n_req != n_eff_q);
    end

    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        lane_ptr_d  = lane_ptr_q;
        n_eff_d     = n_eff_q;
        if (load) begin
            if (any_pop) begin
                data_out_d  = head;
                valid_out_d = 1'b1;
                lane_ptr_d  = ptr_wrap ? '0 : lane_ptr_q + PW'(1);
            end else begin
                valid_out_d = 1'b0;
            end
        end
        // reload only happens with every FIFO empty, so it never races a pop
        if (reload) begin
            n_eff_d    = n_req;
            lane_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            lane_ptr_q  <= '0;
            n_eff_q     <= n_req;
            overflow_q  <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            lane_ptr_q  <= lane_ptr_d;
            n_eff_q     <= n_eff_d;
            for (int unsigned k = 0; k < LANES; k++) begin
                if (valid_in[k] && full[k]) overflow_q[k] <= 1'b1;
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + AW'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + AW'(1);
                cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= data_in[k*WIDTH +: WIDTH];
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign lane_ptr  = lane_ptr_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/mux_unstriping_n.md
Name: mux_unstriping_n

Overview:
- Parametrised successor of the two-lane unstriping mux.
- Merges LANES striped input lanes back into one word stream in strict round-robin lane order (lane 0, 1, …, active_lanes-1, 0, …).
- Each lane has its own DEPTH-entry FIFO, so lanes may arrive skewed. Output has a valid/ready handshake and a programmable active-lane count.
- Sits after the per-lane receive logic, in front of the single-stream consumer.

Parameters:
- WIDTH, 32: bits per data word.
- LANES, 2: number of input lanes, 2..8.
- DEPTH, 4: words per lane FIFO; power of two, >=2.

Ports:
- clk_2f  input  1: single clock; all logic on rising edge.
- reset_L  input  1: synchronous, active-low reset.
- data_in  input  LANES*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
- valid_in  input  LANES: bit k qualifies lane k word this cycle.
- active_lanes  input  clog2(LANES)+1: number of lanes in rotation; 0 or >LANES treated as LANES.
- out_ready  input  1: consumer accepts data_out this cycle.
- data_out  output  WIDTH: registered merged word.
- valid_out  output  1: data_out holds a word.
- lane_ptr  output  clog2(LANES): lane to be read next.
- full  output  LANES: lane FIFO k holds DEPTH words.
- overflow  output  LANES: sticky; a write hit full FIFO k.

Behaviour:
- Reset (reset_L=0 at edge):
  - data_out=0, valid_out=0, lane_ptr=0, full=0, overflow=0.
  - All FIFO pointers cleared. Effective lane count register (n_eff) loaded from active_lanes, sanitised.
  - Reset mid-stream discards all buffered words; there is no partial flush.
- Write: each cycle, for every k < LANES with valid_in[k]=1:
  - If FIFO k is not full, push data_in lane k.
  - If FIFO k is full, drop the word and set overflow[k]=1 until reset.
  - Lanes k >= n_eff are still written, but they are never read.
- Output register update ("load slot" when valid_out=0 or out_ready=1):
  - If FIFO[lane_ptr] is non-empty: data_out<=head, valid_out<=1, pop, lane_ptr<=(lane_ptr+1==n_eff)?0:lane_ptr+1.
  - Else: valid_out<=0, data_out holds its last value, lane_ptr unchanged. Order is never skipped; an empty lane stalls the stream.
  - valid_out=1 and out_ready=0: data_out, valid_out and lane_ptr hold. No pop.
- Latency:
  - A word written at edge t into an empty, selected FIFO with an open load slot appears at data_out after edge t+1.
  - Same-cycle write and read to one FIFO are allowed: the push is not visible to the pop until the next cycle.
  - Simultaneous push and pop on a full FIFO: the push is dropped (full is evaluated before the pop), overflow is set, and the pop proceeds.
- full[k] is combinational from FIFO k's count (count==DEPTH). Counts wrap internally using DEPTH+1 states.
- Sustained throughput: one word per cycle when all active lanes are non-empty and out_ready=1.
- active_lanes change:
  - n_eff reloads only when quiescent: all FIFOs empty and valid_out=0 (or the word is being accepted this cycle).
  - On reload, lane_ptr<=0.
  - Otherwise the new value is ignored until quiescence.
- No combinational path from valid_in or data_in to any output except full.

Test Plan:
- LANES=2, WIDTH=32. Lane0 gets 0xA0,0xA2; lane1 gets 0xA1,0xA3 on the same cycles; out_ready=1 -> data_out 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting one cycle after the first write; lane_ptr 0,1,0,1.
- Skew: lane1 word 0xB1 arrives 3 cycles before lane0 word 0xB0 -> valid_out stays 0 until 0xB0 arrives. Output is then 0xB0 followed by 0xB1, with no reordering.
- Backpressure: out_ready=0 for 4 cycles while streaming -> data_out/valid_out frozen; no word lost. After release, the sequence continues exactly.
- Overflow: DEPTH=4, out_ready=0, 6 writes to lane0 -> full[0]=1 after the 4th stored word (5th write, since one word sits in the output register); overflow[0]=1 after the 6th write. overflow[0] stays 1 after out_ready returns and remains 1 until reset_L=0.
- LANES=4, active_lanes changed 4->3 mid-stream -> rotation stays 0..3 until FIFOs drain, then lane_ptr restarts at 0 and cycles 0,1,2. active_lanes=0 -> rotation over all 4 lanes.
- Reset asserted while 3 words are buffered -> next cycle valid_out=0, data_out=0, full=0, and the buffered words are never output.
